// File: rtl/ct_pkg.sv
// Shared types and constants for the ContrastTransform frame controller.
// Imported by the controller interface and top.
package ct_pkg;

  localparam int CT_SCALE_W = 24;
  localparam logic [CT_SCALE_W-1:0] CT_SCALE_ONE = 24'h001000;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    RUN,
    DRAIN,
    DONE
  } ct_state_e;

  function automatic int ct_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/contrast_frame_ctrl_if.sv
// Pixel-in, datapath and result-out bundle of the frame controller.
// slave = controller side, master = upstream/datapath side.
interface contrast_frame_ctrl_if
  import ct_pkg::*;
#(
  parameter int DW = 24
);

  logic                  in_valid;
  logic                  in_ready;
  logic [DW-1:0]         in_data;
  logic                  ct_enable;
  logic [CT_SCALE_W-1:0] ct_scale;
  logic [DW-1:0]         ct_data;
  logic                  ct_ready;
  logic [DW-1:0]         ct_out;
  logic                  out_valid;
  logic [DW-1:0]         out_data;

  modport slave (
    input  in_valid, in_data,
    input  ct_ready, ct_out,
    output in_ready,
    output ct_enable, ct_scale, ct_data,
    output out_valid, out_data
  );

  modport master (
    output in_valid, in_data,
    output ct_ready, ct_out,
    input  in_ready,
    input  ct_enable, ct_scale, ct_data,
    input  out_valid, out_data
  );

endinterface

// File: rtl/ct_tag_pipe.sv
// Valid-tag shift register that tracks pixels through the datapath.
// o_live reports whether any tag survives the coming edge.
module ct_tag_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_d,
  output logic o_tail,
  output logic o_live
);

  logic [DEPTH-1:0] r_tag;
  logic [DEPTH-1:0] w_nxt;

  assign w_nxt  = DEPTH'({r_tag, i_d});
  assign o_tail = r_tag[DEPTH-1];
  assign o_live = |w_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag <= '0;
    end else if (i_clr) begin
      r_tag <= '0;
    end else begin
      r_tag <= w_nxt;
    end
  end

endmodule

// File: rtl/contrast_frame_ctrl.sv
// Frame sequencer for the ContrastTransform point-operation datapath.
// Scale is latched per frame; results are tagged through the datapath latency.
module contrast_frame_ctrl
  import ct_pkg::*;
#(
  parameter int color_channels = 3,
  parameter int color_width    = 8,
  parameter int mul_delay      = 0,
  parameter int im_width       = 320,
  parameter int im_height      = 240
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CT_SCALE_W-1:0] cfg_scale,
  input  logic                  cfg_we,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  frame_done,
  contrast_frame_ctrl_if.slave  bus
);

  localparam int DW   = color_channels * color_width;
  localparam int L    = mul_delay + 1;
  localparam int NPIX = im_width * im_height;
  localparam int CNTW = ct_cnt_w(NPIX);
  localparam logic [CNTW-1:0] LAST = CNTW'(NPIX - 1);

  ct_state_e             r_state;
  logic [CT_SCALE_W-1:0] r_pend;
  logic [CT_SCALE_W-1:0] r_active;
  logic [CNTW-1:0]       r_cnt;
  logic [DW-1:0]         r_ct_data;
  logic                  r_ct_vld;
  logic                  r_ct_enable;
  logic                  r_in_ready;
  logic                  r_busy;
  logic                  r_done;

  logic w_accept;
  logic w_abort;
  logic w_clr;
  logic w_tail;
  logic w_live;

  assign w_accept = bus.in_valid & r_in_ready;
  assign w_abort  = abort & (r_state != IDLE);
  assign w_clr    = ~r_ct_enable | w_abort;

  // Tags enter one cycle after accept, when ct_data reaches the datapath.
  ct_tag_pipe #(
    .DEPTH (L)
  ) u_tag (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_clr),
    .i_d    (r_ct_vld),
    .o_tail (w_tail),
    .o_live (w_live)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_pend      <= CT_SCALE_ONE;
      r_active    <= CT_SCALE_ONE;
      r_cnt       <= '0;
      r_ct_data   <= '0;
      r_ct_vld    <= 1'b0;
      r_ct_enable <= 1'b0;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_ct_vld <= w_accept;
      if (cfg_we) r_pend <= cfg_scale;
      if (w_accept) r_ct_data <= bus.in_data;
      if (w_abort) begin
        r_state     <= IDLE;
        r_cnt       <= '0;
        r_ct_vld    <= 1'b0;
        r_ct_enable <= 1'b0;
        r_in_ready  <= 1'b0;
        r_busy      <= 1'b0;
      end else begin
        unique case (r_state)
          IDLE: begin
            if (start) begin
              r_active    <= cfg_we ? cfg_scale : r_pend;
              r_state     <= ARM;
              r_cnt       <= '0;
              r_ct_enable <= 1'b1;
              r_busy      <= 1'b1;
            end
          end
          ARM: begin
            r_state    <= RUN;
            r_in_ready <= 1'b1;
          end
          RUN: begin
            if (w_accept) begin
              if (r_cnt == LAST) begin
                r_cnt      <= '0;
                r_state    <= DRAIN;
                r_in_ready <= 1'b0;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
          end
          DRAIN: begin
            // Leave as the last tag reaches the tail.
            if (!w_live) begin
              r_state     <= DONE;
              r_ct_enable <= 1'b0;
              r_done      <= 1'b1;
            end
          end
          DONE: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign busy          = r_busy;
  assign frame_done    = r_done;
  assign bus.in_ready  = r_in_ready;
  assign bus.ct_enable = r_ct_enable;
  assign bus.ct_scale  = r_active;
  assign bus.ct_data   = r_ct_data;
  assign bus.out_valid = w_tail & bus.ct_ready;
  assign bus.out_data  = bus.out_valid ? bus.ct_out : '0;

endmodule
